// File: rtl/txpippm_step_scheduler.sv
// rtl/txpippm_step_scheduler.sv - round-robin PI step scheduler for the TX PPM controller bank
// Optional saturation sticky status is built when TXPIPPM_SCHED_SAT_STATUS_EN is defined.
module txpippm_step_scheduler #(
  parameter int CHANNEL_COUNT = 10,
  parameter int ACC_WIDTH     = 12,
  parameter int MAX_STEP      = 15,
  parameter int GAP_CYCLES    = 8,
  localparam int CW = (CHANNEL_COUNT > 1) ? $clog2(CHANNEL_COUNT) : 1
) (
  input  logic                     gtwiz_userclk_tx_usrclk_in,
  input  logic                     gtwiz_reset_all_in,
  input  logic                     gtwiz_userclk_tx_active_in,
  input  logic                     cmd_valid_in,
  input  logic [CW-1:0]            cmd_channel_in,
  input  logic [ACC_WIDTH-1:0]     cmd_steps_in,
  input  logic                     flush_in,
`ifdef TXPIPPM_SCHED_SAT_STATUS_EN
  input  logic                     sat_clear_in,
  output logic [CHANNEL_COUNT-1:0] sat_sticky_out,
`endif
  output logic [CHANNEL_COUNT-1:0] sel_out,
  output logic                     pulse_out,
  output logic [4:0]               stepsize_out,
  output logic                     busy_out
);
  localparam int SW = ACC_WIDTH + 2;
  localparam int GW = $clog2(GAP_CYCLES + 1);
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_GAP   = 2'd2;
  localparam logic signed [SW-1:0] SUM_MAX = SW'(2 ** (ACC_WIDTH - 1) - 1);
  localparam logic signed [SW-1:0] SUM_MIN = -SUM_MAX - SW'(1);

  logic [1:0]                  state_q, state_d;
  logic [CW-1:0]               ptr_q, ptr_d, cur_q, cur_d;
  logic [GW-1:0]               gap_q, gap_d;
  logic signed [ACC_WIDTH-1:0] pend_q [CHANNEL_COUNT];
  logic signed [ACC_WIDTH-1:0] pend_d [CHANNEL_COUNT];
  logic [CHANNEL_COUNT-1:0]    sel_q, sel_d;
  logic                        pulse_q, pulse_d, busy_q, busy_d;
  logic [4:0]                  step_q, step_d;
  logic signed [SW-1:0]        issued, sum;
  logic                        found, any_pend;
  logic [CW-1:0]               cand;
  int                          idx;
  logic signed [ACC_WIDTH-1:0] next_val;
  logic [ACC_WIDTH:0]          next_abs;
`ifdef TXPIPPM_SCHED_SAT_STATUS_EN
  logic [CHANNEL_COUNT-1:0]    sat_set, sticky_q;
`endif

  // Request and the in-flight pulse are folded into one saturating update per channel.
  always_comb begin
    issued = {{(SW-4){1'b0}}, step_q[3:0]};
    if (!step_q[4]) issued = -issued;
    sum = '0;
`ifdef TXPIPPM_SCHED_SAT_STATUS_EN
    sat_set = '0;
`endif
    for (int i = 0; i < CHANNEL_COUNT; i++) begin
      sum = SW'(pend_q[i]);
      if (cmd_valid_in && cmd_channel_in == CW'(i)) sum = sum + SW'(signed'(cmd_steps_in));
      if (state_q == ST_ISSUE && cur_q == CW'(i)) sum = sum - issued;
      if (sum > SUM_MAX) begin
        pend_d[i] = SUM_MAX[ACC_WIDTH-1:0];
`ifdef TXPIPPM_SCHED_SAT_STATUS_EN
        sat_set[i] = 1'b1;
`endif
      end else if (sum < SUM_MIN) begin
        pend_d[i] = SUM_MIN[ACC_WIDTH-1:0];
`ifdef TXPIPPM_SCHED_SAT_STATUS_EN
        sat_set[i] = 1'b1;
`endif
      end else begin
        pend_d[i] = sum[ACC_WIDTH-1:0];
      end
      if (flush_in) begin
        pend_d[i] = '0;
`ifdef TXPIPPM_SCHED_SAT_STATUS_EN
        sat_set[i] = 1'b0;
`endif
      end
    end
  end

  always_comb begin
    found = 1'b0;
    cand  = ptr_q;
    idx   = 0;
    for (int k = 0; k < CHANNEL_COUNT; k++) begin
      idx = int'(ptr_q) + k;
      if (idx >= CHANNEL_COUNT) idx = idx - CHANNEL_COUNT;
      if (!found && pend_q[idx] != '0) begin
        found = 1'b1;
        cand  = CW'(idx);
      end
    end
  end

  // Magnitude uses the value the channel will hold in the ISSUE cycle.
  always_comb begin
    next_val = pend_d[cand];
    next_abs = {next_val[ACC_WIDTH-1], next_val};
    if (next_val[ACC_WIDTH-1]) next_abs = -next_abs;
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cur_d   = cur_q;
    gap_d   = gap_q;
    pulse_d = 1'b0;
    sel_d   = '0;
    step_d  = step_q;
    case (state_q)
      ST_IDLE: begin
        if (gtwiz_userclk_tx_active_in && found) begin
          state_d = ST_ISSUE;
          cur_d   = cand;
          pulse_d = 1'b1;
          sel_d   = CHANNEL_COUNT'(1) << cand;
          step_d[4] = ~next_val[ACC_WIDTH-1];
          step_d[3:0] = (next_abs > (ACC_WIDTH+1)'(MAX_STEP)) ? 4'(MAX_STEP) : next_abs[3:0];
        end
      end
      ST_ISSUE: begin
        state_d = ST_GAP;
        gap_d   = GW'(GAP_CYCLES - 1);
        ptr_d   = (cur_q == CW'(CHANNEL_COUNT - 1)) ? '0 : cur_q + 1'b1;
      end
      default: begin
        if (gap_q == '0) state_d = ST_IDLE;
        else gap_d = gap_q - 1'b1;
      end
    endcase
    any_pend = 1'b0;
    for (int i = 0; i < CHANNEL_COUNT; i++) any_pend = any_pend | (pend_d[i] != '0);
    busy_d = any_pend || (state_d != ST_IDLE);
  end

  always_ff @(posedge gtwiz_userclk_tx_usrclk_in or posedge gtwiz_reset_all_in) begin
    if (gtwiz_reset_all_in) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      cur_q   <= '0;
      gap_q   <= '0;
      pulse_q <= 1'b0;
      sel_q   <= '0;
      step_q  <= '0;
      busy_q  <= 1'b0;
      for (int i = 0; i < CHANNEL_COUNT; i++) pend_q[i] <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cur_q   <= cur_d;
      gap_q   <= gap_d;
      pulse_q <= pulse_d;
      sel_q   <= sel_d;
      step_q  <= step_d;
      busy_q  <= busy_d;
      for (int i = 0; i < CHANNEL_COUNT; i++) pend_q[i] <= pend_d[i];
    end
  end

`ifdef TXPIPPM_SCHED_SAT_STATUS_EN
  // A same-cycle set wins over clear so no saturation event is lost.
  always_ff @(posedge gtwiz_userclk_tx_usrclk_in or posedge gtwiz_reset_all_in) begin
    if (gtwiz_reset_all_in) sticky_q <= '0;
    else sticky_q <= (sticky_q & ~{CHANNEL_COUNT{sat_clear_in}}) | sat_set;
  end
  assign sat_sticky_out = sticky_q;
`endif

  assign pulse_out    = pulse_q;
  assign sel_out      = sel_q;
  assign stepsize_out = step_q;
  assign busy_out     = busy_q;
endmodule

// File: tb/tb_txpippm_step_scheduler.sv
// tb/tb_txpippm_step_scheduler.sv - directed bench with per-cycle reference model for txpippm_step_scheduler
module tb_txpippm_step_scheduler;
  localparam int C   = 10;
  localparam int GAP = 8;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              active = 1'b1;
  logic              cmd_valid = 1'b0;
  logic [3:0]        cmd_channel = '0;
  logic signed [11:0] cmd_steps = '0;
  logic              flush = 1'b0;
  logic [C-1:0]      sel;
  logic              pulse;
  logic [4:0]        step;
  logic              busy;
`ifdef TXPIPPM_SCHED_SAT_STATUS_EN
  logic              sat_clear = 1'b0;
  logic [C-1:0]      sticky;
  logic [C-1:0]      e_sticky, sset;
`endif

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  // reference model state
  int pend [C];
  int ptr, since, e_ch, dec, dch, amt, v, m, c2, any;
  logic [C-1:0] e_sel;
  logic [4:0]   e_step;
  logic         e_pulse, e_busy, sat;

  txpippm_step_scheduler dut (
    .gtwiz_userclk_tx_usrclk_in (clk),
    .gtwiz_reset_all_in         (rst),
    .gtwiz_userclk_tx_active_in (active),
    .cmd_valid_in               (cmd_valid),
    .cmd_channel_in             (cmd_channel),
    .cmd_steps_in               (cmd_steps),
    .flush_in                   (flush),
`ifdef TXPIPPM_SCHED_SAT_STATUS_EN
    .sat_clear_in               (sat_clear),
    .sat_sticky_out             (sticky),
`endif
    .sel_out                    (sel),
    .pulse_out                  (pulse),
    .stepsize_out               (step),
    .busy_out                   (busy)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
  endtask

  // Model: pulses follow from pending counts, a round-robin pointer and cycles since the last pulse.
  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) begin
      for (int c = 0; c < C; c++) pend[c] = 0;
      ptr = 0; since = 1000; e_ch = 0; e_pulse = 1'b0; e_sel = '0; e_step = '0; e_busy = 1'b0;
`ifdef TXPIPPM_SCHED_SAT_STATUS_EN
      e_sticky = '0;
`endif
    end else begin
      dec = 0; dch = 0;
      if (!e_pulse && since > GAP && active)
        for (int k = 0; k < C; k++) begin
          c2 = (ptr + k) % C;
          if (dec == 0 && pend[c2] != 0) begin dec = 1; dch = c2; end
        end
      amt = e_step[4] ? int'(e_step[3:0]) : -int'(e_step[3:0]);
      for (int c = 0; c < C; c++) begin
        v = pend[c]; sat = 1'b0;
        if (cmd_valid && int'(cmd_channel) == c) v = v + int'(cmd_steps);
        if (e_pulse && e_ch == c) v = v - amt;
        if (v > 2047) begin v = 2047; sat = 1'b1; end
        else if (v < -2048) begin v = -2048; sat = 1'b1; end
        if (flush) begin v = 0; sat = 1'b0; end
        pend[c] = v;
`ifdef TXPIPPM_SCHED_SAT_STATUS_EN
        sset[c] = sat;
`endif
      end
`ifdef TXPIPPM_SCHED_SAT_STATUS_EN
      e_sticky = (e_sticky & ~{C{sat_clear}}) | sset;
`endif
      if (e_pulse) ptr = (e_ch + 1) % C;
      since = e_pulse ? 1 : ((since < 1000) ? since + 1 : since);
      e_pulse = (dec != 0);
      e_sel = '0;
      if (dec != 0) begin
        e_ch = dch;
        e_sel = 10'd1 << dch;
        m = (pend[dch] < 0) ? -pend[dch] : pend[dch];
        if (m > 15) m = 15;
        e_step = {pend[dch] >= 0, 4'(m)};
      end
      any = 0;
      for (int c = 0; c < C; c++) if (pend[c] != 0) any = 1;
      e_busy = (any != 0) || (dec != 0) || (since <= GAP);
    end
  end

  initial forever begin
    @(negedge clk);
    check("cyc_pulse", pulse, e_pulse);
    check("cyc_sel", sel, e_sel);
    check("cyc_step", step, e_step);
    check("cyc_busy", busy, e_busy);
`ifdef TXPIPPM_SCHED_SAT_STATUS_EN
    check("cyc_sticky", sticky, e_sticky);
`endif
  end

  task automatic req(input int ch, input int steps);
    cmd_valid = 1'b1; cmd_channel = 4'(ch); cmd_steps = 12'(steps);
    @(negedge clk);
    cmd_valid = 1'b0; cmd_channel = '0; cmd_steps = '0;
  endtask

  task automatic wait_to(input int at);
    while (cyc < at) @(negedge clk);
  endtask

  task automatic expect_pulse(input int at, input logic [C-1:0] s, input logic [4:0] st, input string nm);
    wait_to(at);
    check({nm, "_time"}, cyc, at);
    check({nm, "_pulse"}, pulse, 1'b1);
    check({nm, "_sel"}, sel, s);
    check({nm, "_step"}, step, st);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int r, s, cnt;
    repeat (3) @(negedge clk);
    check("rst_pulse", pulse, 1'b0);
    check("rst_sel", sel, 0);
    check("rst_step", step, 0);
    check("rst_busy", busy, 1'b0);
    rst = 1'b0;
    @(negedge clk);

    r = cyc; req(3, 40);
    expect_pulse(r + 2,  10'h008, 5'h1F, "t1_p1");
    expect_pulse(r + 12, 10'h008, 5'h1F, "t1_p2");
    expect_pulse(r + 22, 10'h008, 5'h1A, "t1_p3");
    wait_to(r + 32);
    check("t1_busy_low", busy, 1'b0);

    r = cyc; req(0, -7);
    expect_pulse(r + 2, 10'h001, 5'h07, "t2_neg");
    wait_to(r + 14);

    rst = 1'b1; @(negedge clk); rst = 1'b0; @(negedge clk);
    r = cyc; req(1, 15); req(8, 15);
    expect_pulse(r + 2,  10'h002, 5'h1F, "t3_ch1");
    expect_pulse(r + 12, 10'h100, 5'h1F, "t3_ch8");
    req(0, 1); req(5, 1);
    expect_pulse(r + 22, 10'h001, 5'h11, "t3_wrap0");
    expect_pulse(r + 32, 10'h020, 5'h11, "t3_ch5");
    wait_to(r + 42);

    r = cyc; req(2, 20);
    expect_pulse(r + 2, 10'h004, 5'h1F, "t4_p1");
    req(2, 5);
    expect_pulse(r + 12, 10'h004, 5'h1A, "t4_p2");
    wait_to(r + 24);
    check("t4_busy_low", busy, 1'b0);

    active = 1'b0;
    req(5, 3);
    repeat (5) @(negedge clk);
    check("t5_hold_busy", busy, 1'b1);
    check("t5_hold_pulse", pulse, 1'b0);
    s = cyc; active = 1'b1;
    expect_pulse(s + 1, 10'h020, 5'h13, "t5_resume");
    @(negedge clk);
    req(6, 30);
    flush = 1'b1; @(negedge clk); flush = 1'b0;
    cnt = 0;
    repeat (30) begin
      @(negedge clk);
      if (pulse) cnt++;
    end
    check("t5_flush_pulses", cnt, 0);
    check("t5_flush_busy", busy, 1'b0);

    r = cyc; req(4, 2047); req(4, 2047);
    expect_pulse(r + 2, 10'h010, 5'h1F, "t6_p1");
`ifdef TXPIPPM_SCHED_SAT_STATUS_EN
    check("t6_sticky_set", sticky[4], 1'b1);
    sat_clear = 1'b1; @(negedge clk); sat_clear = 1'b0;
    check("t6_sticky_clr", sticky[4], 1'b0);
`else
    @(negedge clk);
`endif
    @(negedge clk);
    rst = 1'b1; #1;
    check("t6_arst_pulse", pulse, 1'b0);
    check("t6_arst_sel", sel, 0);
    check("t6_arst_step", step, 0);
    check("t6_arst_busy", busy, 1'b0);
`ifdef TXPIPPM_SCHED_SAT_STATUS_EN
    check("t6_arst_sticky", sticky, 0);
`endif
    @(negedge clk); rst = 1'b0;
    repeat (3) @(negedge clk);
    check("t6_post_busy", busy, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/txpippm_step_scheduler.md
Name: txpippm_step_scheduler

Overview:
Round-robin scheduler that drives the shared pulse/stepsize bus and per-channel select lines of the multi-channel TX phase-interpolator PPM controller bank.
- Accepts signed phase-step requests per channel and accumulates them into per-channel pending counters.
- Splits each counter into PI pulses of at most MAX_STEP steps, spaced by a programmable gap.
- Sits in the TXUSRCLK domain between the phase-tracking logic and the controller bank.

Parameters:
CHANNEL_COUNT, 10, number of channels served; range 1..32.
ACC_WIDTH, 12, width of each signed pending-step accumulator.
MAX_STEP, 15, largest magnitude issued per pulse; range 1..15.
GAP_CYCLES, 8, idle cycles after each pulse before the next pulse may issue; minimum 1.

Ports:
gtwiz_userclk_tx_usrclk_in  input  1  TXUSRCLK; sole clock.
gtwiz_reset_all_in  input  1  reset, asynchronous, active-high.
gtwiz_userclk_tx_active_in  input  1  pulses are issued only while high.
cmd_valid_in  input  1  request strobe; one request per cycle.
cmd_channel_in  input  $clog2(CHANNEL_COUNT) (min 1)  target channel.
cmd_steps_in  input  ACC_WIDTH  signed step request; positive = advance phase.
flush_in  input  1  synchronously clears all pending counters.
sel_out  output  CHANNEL_COUNT  one-hot channel select; valid only while pulse_out is high.
pulse_out  output  1  single-cycle step strobe.
stepsize_out  output  5  bit4 = direction (1 = increment), bits3:0 = magnitude.
busy_out  output  1  high when any pending counter is nonzero or the FSM is not in IDLE.

Behaviour:
- Reset: all pending counters 0, round-robin pointer 0, FSM IDLE. Outputs: sel_out 0, pulse_out 0, stepsize_out 0, busy_out 0. Reset asserted mid-operation aborts immediately; no partial pulse is emitted.
- Request accumulate:
  - If cmd_valid_in is high and cmd_channel_in < CHANNEL_COUNT, then pending[ch] <= sat(pending[ch] + cmd_steps_in - issued[ch]).
  - Saturation is at the signed ACC_WIDTH limits.
  - An out-of-range channel index is ignored.
  - issued[ch] is the signed amount decremented in the same cycle (nonzero only in ISSUE). Simultaneous request and issue on the same channel therefore combine in one update, and neither is lost.
- flush_in: clears all pending counters and overrides any same-cycle request or decrement. It does not abort a GAP already in progress.
- FSM states:
  - IDLE: if gtwiz_userclk_tx_active_in = 1 and any pending != 0, select the first nonzero channel searching from pointer, wrapping modulo CHANNEL_COUNT. Register the selection and go to ISSUE. Otherwise stay in IDLE.
  - ISSUE (1 cycle):
    - pulse_out = 1 and sel_out = one-hot(selected channel).
    - stepsize_out = {sign>=0, min(|pending|, MAX_STEP)}.
    - pending[sel] is moved toward 0 by that magnitude.
    - pointer <= sel+1, wrapping modulo CHANNEL_COUNT.
    - Next state is GAP.
  - GAP: count GAP_CYCLES cycles with pulse_out = 0 and sel_out = 0, then go to IDLE. The gap completes even if gtwiz_userclk_tx_active_in drops.
- Direction: a positive pending count gives bit4 = 1; a negative count gives bit4 = 0 with magnitude taken from the absolute value. The most-negative accumulator value is handled without overflow.
- If the selected channel's pending value becomes 0 through a same-cycle request between IDLE and ISSUE, the ISSUE cycle is still emitted, with magnitude 0 and direction bit4 = 1.
- stepsize_out holds its last issued value between pulses. sel_out is zero whenever pulse_out is low.
- Latency: a request accepted in cycle N with the FSM in IDLE produces pulse_out in cycle N+2.
- Throughput: at most one pulse per GAP_CYCLES+2 cycles, shared across all channels.
- gtwiz_userclk_tx_active_in low: pending counters keep accumulating requests; no new pulse is issued.
- All outputs are registered.

Optional Feature:
Macro TXPIPPM_SCHED_SAT_STATUS_EN.
- When defined:
  - Adds port sat_sticky_out (output, CHANNEL_COUNT): bit ch sets when pending[ch] saturates.
  - Adds port sat_clear_in (input, 1): clears all sticky bits synchronously. A set and a clear in the same cycle leave the bit set.
  - sat_sticky_out resets to 0.
- When undefined: neither port exists, no sticky logic is built, and saturation stays silent.

Test Plan:
- Reset released, active = 1, request ch3 +40 → pulses on ch3 (sel_out = 0x008) with stepsize 0x1F, 0x1F, 0x1A. First pulse at N+2; subsequent pulses every GAP_CYCLES+2 = 10 cycles. pending[3] ends at 0 and busy_out falls.
- Request ch0 −7 → one pulse, stepsize_out = 0x07, sel_out = 0x001.
- Requests ch1 +15 and ch8 +15 in consecutive cycles, with the pointer at 0 → ch1 is served first, then ch8. After ch8, the search starts at ch9 and wraps to 0.
- During ch2's ISSUE cycle (pending +20, issuing 15), request ch2 +5 → pending[2] = 10 afterwards, giving a further pulse of 0x1A.
- Hold active = 0, request ch5 +3 → no pulse while active is low and busy_out = 1. Raise active → pulse 0x13 in the cycle after IDLE samples active high. flush_in during a GAP → pending is cleared, the gap finishes, and no further pulses follow.
- With ACC_WIDTH = 12 and the macro defined, request ch4 +2047 twice → pending[4] = 2047 and sat_sticky_out[4] = 1. Assert sat_clear_in → sticky bit clears. Assert the async reset mid-GAP → all outputs 0 immediately.
